// File: rtl/opr3_pkg.sv
// opr3 group-3 operate sequencer: shared state and shift-code constants.
// The OPR3_SHIFT_EN build macro enables the SHIFT state and step counter.
package opr3_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLA   = 3'd1;
  localparam logic [2:0] ST_MQ    = 3'd2;
  localparam logic [2:0] ST_SCA   = 3'd3;
  localparam logic [2:0] ST_SHIFT = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [1:0] SH_NONE = 2'd0;
  localparam logic [1:0] SH_ASR  = 2'd1;
  localparam logic [1:0] SH_LSR  = 2'd2;
  localparam logic [1:0] SH_SHL  = 2'd3;

  // States are numbered in execution order, so the next needed
  // state is the first enabled one numerically above cur.
  function automatic logic [2:0] next_after(
    input logic [2:0] cur,
    input logic       b_cla,
    input logic       b_mq,
    input logic       b_sca,
    input logic       b_sh
  );
    logic [2:0] n;
    n = ST_DONE;
    if (cur < ST_CLA && b_cla)
      n = ST_CLA;
    else if (cur < ST_MQ && b_mq)
      n = ST_MQ;
    else if (cur < ST_SCA && b_sca)
      n = ST_SCA;
    else if (cur < ST_SHIFT && b_sh)
      n = ST_SHIFT;
    return n;
  endfunction

endpackage

// File: rtl/opr3_step_cnt.sv
// opr3 shift step counter: load, saturating decrement, zero flag.
// Only instantiated when OPR3_SHIFT_EN is defined.
module opr3_step_cnt #(
  parameter int CNTW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [CNTW-1:0] load_val,
  input  logic            dec,
  output logic [CNTW-1:0] cnt,
  output logic            zero
);

  assign zero = (cnt == '0);

  // Load takes priority; decrement stops at zero so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && !zero)
      cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/opr3_sequencer.sv
// opr3 group-3 operate sequencer: CLA, MQ, SCA, SHIFT strobe timing.
// Build macro OPR3_SHIFT_EN adds the SHIFT state and step counter.
module opr3_sequencer
  import opr3_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             oprCLA,
  input  logic             oprMQA,
  input  logic             oprSCA,
  input  logic             oprMQL,
  input  logic [1:0]       shift_code,
  input  logic [CNTW-1:0]  shift_cnt,
  output logic             busy,
  output logic             cla,
  output logic             ac_ck,
  output logic             mq_ck,
  output logic             mq2orbus,
  output logic             sc2orbus,
  output logic             shift_en,
  output logic [1:0]       shift_op,
  output logic [WIDTH-1:0] sc_val,
  output logic             done
);

  logic [2:0] state;
  logic [2:0] nxt;
  logic       take;
  logic       c_cla, c_mqa, c_mql, c_sca;
  logic       e_cla, e_mqa, e_mql, e_sca;
  logic       e_sh;
  logic       cnt_zero;

  assign take = (state == ST_IDLE) && start;

  // On the accepting edge the fresh inputs decide the path;
  // afterwards only the captured copy is used.
  always_comb begin
    e_cla = c_cla;
    e_mqa = c_mqa;
    e_mql = c_mql;
    e_sca = c_sca;
    if (take) begin
      e_cla = oprCLA;
      e_mqa = oprMQA;
      e_mql = oprMQL;
      e_sca = oprSCA;
    end
  end

  // Capture microbits only when a request is accepted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_cla <= 1'b0;
      c_mqa <= 1'b0;
      c_mql <= 1'b0;
      c_sca <= 1'b0;
    end else if (take) begin
      c_cla <= oprCLA;
      c_mqa <= oprMQA;
      c_mql <= oprMQL;
      c_sca <= oprSCA;
    end
  end

`ifdef OPR3_SHIFT_EN
  logic [1:0]      c_code;
  logic [CNTW-1:0] c_cnt;
  logic [1:0]      e_code;
  logic [CNTW-1:0] e_cnt;
  logic [CNTW-1:0] cnt;
  logic            sh_en_q;
  logic [1:0]      sh_op_q;

  assign e_code = take ? shift_code : c_code;
  assign e_cnt  = take ? shift_cnt  : c_cnt;
  assign e_sh   = (e_code != SH_NONE);

  // Shift operands are captured alongside the microbits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_code <= SH_NONE;
      c_cnt  <= '0;
    end else if (take) begin
      c_code <= shift_code;
      c_cnt  <= shift_cnt;
    end
  end

  opr3_step_cnt #(
    .CNTW (CNTW)
  ) u_step_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     ((nxt == ST_SHIFT) && (state != ST_SHIFT)),
    .load_val (e_cnt),
    .dec      (state == ST_SHIFT),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // Shift strobe and opcode are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_en_q <= 1'b0;
      sh_op_q <= SH_NONE;
    end else begin
      sh_en_q <= (nxt == ST_SHIFT);
      sh_op_q <= (nxt == ST_SHIFT) ? e_code : SH_NONE;
    end
  end

  assign shift_en = sh_en_q;
  assign shift_op = sh_op_q;
  assign sc_val   = WIDTH'(cnt);
`else
  logic unused_shift;

  assign unused_shift = ^{shift_code, shift_cnt};
  assign e_sh     = 1'b0;
  assign cnt_zero = 1'b1;
  assign shift_en = 1'b0;
  assign shift_op = SH_NONE;
  assign sc_val   = '0;
`endif

  // Next-state selection; a start seen outside IDLE is ignored.
  always_comb begin
    nxt = ST_IDLE;
    unique case (state)
      ST_IDLE:
        nxt = start ? next_after(ST_IDLE, e_cla,
                        e_mqa | e_mql, e_sca, e_sh)
                    : ST_IDLE;
      ST_SHIFT:
        nxt = cnt_zero ? ST_DONE : ST_SHIFT;
      ST_DONE:
        nxt = ST_IDLE;
      default:
        nxt = next_after(state, e_cla,
                e_mqa | e_mql, e_sca, e_sh);
    endcase
  end

  // State plus strobes registered from the next state, so every
  // output is a flop and changes only on the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      cla      <= 1'b0;
      ac_ck    <= 1'b0;
      mq_ck    <= 1'b0;
      mq2orbus <= 1'b0;
      sc2orbus <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= nxt;
      busy     <= (nxt != ST_IDLE);
      cla      <= (nxt == ST_CLA) ||
                  ((nxt == ST_MQ) && e_mql);
      ac_ck    <= (nxt == ST_CLA) || (nxt == ST_MQ) ||
                  (nxt == ST_SCA);
      mq_ck    <= (nxt == ST_MQ) && e_mql;
      mq2orbus <= (nxt == ST_MQ) && e_mqa;
      sc2orbus <= (nxt == ST_SCA);
      done     <= (nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_opr3_sequencer.sv
// Scoreboard bench for opr3_sequencer: per-cycle expected strobe
// vectors are queued at start and compared every falling edge.
module tb_opr3_sequencer;

`ifdef OPR3_SHIFT_EN
  localparam bit SHIFT_ON = 1'b1;
`else
  localparam bit SHIFT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        oprCLA = 1'b0;
  logic        oprMQA = 1'b0;
  logic        oprSCA = 1'b0;
  logic        oprMQL = 1'b0;
  logic [1:0]  shift_code = 2'd0;
  logic [4:0]  shift_cnt = 5'd0;
  logic        busy, cla, ac_ck, mq_ck;
  logic        mq2orbus, sc2orbus, shift_en, done;
  logic [1:0]  shift_op;
  logic [11:0] sc_val;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  opr3_sequencer #(
    .WIDTH (12),
    .CNTW  (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .oprCLA     (oprCLA),
    .oprMQA     (oprMQA),
    .oprSCA     (oprSCA),
    .oprMQL     (oprMQL),
    .shift_code (shift_code),
    .shift_cnt  (shift_cnt),
    .busy       (busy),
    .cla        (cla),
    .ac_ck      (ac_ck),
    .mq_ck      (mq_ck),
    .mq2orbus   (mq2orbus),
    .sc2orbus   (sc2orbus),
    .shift_en   (shift_en),
    .shift_op   (shift_op),
    .sc_val     (sc_val),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs();
    return {10'b0, sc_val, busy, cla, ac_ck, mq_ck,
            mq2orbus, sc2orbus, shift_en, shift_op, done};
  endfunction

  function automatic logic [31:0] mk(
    input int sc, input logic b, input logic c,
    input logic a, input logic m, input logic mo,
    input logic so, input logic se,
    input logic [1:0] op, input logic d);
    logic [11:0] s;
    s = sc[11:0];
    return {10'b0, s, b, c, a, m, mo, so, se, op, d};
  endfunction

  task automatic model(input logic b_cla, input logic b_mqa,
                       input logic b_mql, input logic b_sca,
                       input logic [1:0] code,
                       input logic [4:0] n);
    if (b_cla)
      exp_q.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 2'd0, 0));
    if (b_mqa || b_mql)
      exp_q.push_back(mk(0, 1, b_mql, 1, b_mql, b_mqa,
                         0, 0, 2'd0, 0));
    if (b_sca)
      exp_q.push_back(mk(0, 1, 0, 1, 0, 0, 1, 0, 2'd0, 0));
    if (SHIFT_ON && code != 2'd0)
      for (int i = int'(n); i >= 0; i--)
        exp_q.push_back(mk(i, 1, 0, 0, 0, 0, 0, 1, code, 0));
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 1));
  endtask

  // Pops one expected vector per cycle; idle cycles must be quiet.
  always @(negedge clk) begin
    if (exp_q.size() > 0)
      check("seq", obs(), exp_q.pop_front());
    else
      check("idle", obs(), 32'd0);
  end

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() > 0; i++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    #1;
  endtask

  // Call at posedge+1; start is sampled on the following edge.
  task automatic run_op(input logic b_cla, input logic b_mqa,
                        input logic b_mql, input logic b_sca,
                        input logic [1:0] code,
                        input logic [4:0] n,
                        input bit dbl);
    start = 1'b1;
    oprCLA = b_cla;
    oprMQA = b_mqa;
    oprMQL = b_mql;
    oprSCA = b_sca;
    shift_code = code;
    shift_cnt = n;
    @(posedge clk);
    #1;
    model(b_cla, b_mqa, b_mql, b_sca, code, n);
    if (dbl) begin
      oprCLA = 1'b1;
      oprSCA = 1'b1;
      oprMQA = ~b_mqa;
      shift_code = 2'd3;
      shift_cnt = 5'd7;
      repeat (2) begin
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    oprCLA = 1'b0;
    oprMQA = 1'b0;
    oprMQL = 1'b0;
    oprSCA = 1'b0;
    drain();
  endtask

  initial begin
    #2;
    check("reset", obs(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(0, 0, 0, 0, 2'd0, 5'd0, 0);
    run_op(1, 1, 1, 0, 2'd0, 5'd0, 0);
    run_op(0, 1, 0, 0, 2'd0, 5'd0, 0);
    run_op(0, 0, 1, 0, 2'd0, 5'd0, 0);
    run_op(0, 0, 0, 1, 2'd0, 5'd9, 0);
    run_op(0, 0, 0, 0, 2'd2, 5'd3, 0);
    run_op(1, 0, 0, 1, 2'd3, 5'd31, 0);
    run_op(0, 1, 1, 1, 2'd1, 5'd0, 0);
    run_op(0, 0, 1, 0, 2'd0, 5'd0, 1);

    // Reset lands in the second SHIFT cycle.
    start = 1'b1;
    shift_code = 2'd2;
    shift_cnt = 5'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    model(0, 0, 0, 0, 2'd2, 5'd3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_mid", obs(), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(1, 0, 0, 0, 2'd2, 5'd3, 0);

    for (int k = 0; k < 8; k++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      run_op(r[0], r[1], r[2], r[3],
             2'($urandom_range(0, 3)),
             5'($urandom_range(0, 6)), k[0]);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
